// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES inverse-cipher types, inverse S-box and GF(2^8) helpers.
package aes_inv_cipher_pkg;

  localparam int unsigned BLK_W = 128;

  // Byte 0 sits in the MSBs; byte index = 4*column + row.
  typedef logic [0:15][7:0] aes_state_t;
  typedef logic [0:3][7:0]  aes_col_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_LAST, S_DONE} fsm_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant of at most 4 bits (all InvMixColumns needs).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic aes_col_t inv_mix_col(input aes_col_t a);
    aes_col_t b;
    b[0] = gf_mul(a[0], 4'he) ^ gf_mul(a[1], 4'hb) ^ gf_mul(a[2], 4'hd) ^ gf_mul(a[3], 4'h9);
    b[1] = gf_mul(a[0], 4'h9) ^ gf_mul(a[1], 4'he) ^ gf_mul(a[2], 4'hb) ^ gf_mul(a[3], 4'hd);
    b[2] = gf_mul(a[0], 4'hd) ^ gf_mul(a[1], 4'h9) ^ gf_mul(a[2], 4'he) ^ gf_mul(a[3], 4'hb);
    b[3] = gf_mul(a[0], 4'hb) ^ gf_mul(a[1], 4'hd) ^ gf_mul(a[2], 4'h9) ^ gf_mul(a[3], 4'he);
    return b;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_cipher_round
  import aes_inv_cipher_pkg::*;
(
  input  aes_state_t state_i,
  input  aes_state_t rkey_i,
  input  logic       last_i,
  output aes_state_t state_o
);

  aes_state_t sb;
  aes_state_t ark;
  aes_state_t mixed;

  // Row r rotates right by r columns, fused with the S-box lookup.
  always_comb begin
    sb    = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[4*c+r] = INV_SBOX[state_i[4*((c-r+4)%4)+r]];
      end
    end
    ark = sb ^ rkey_i;
    for (int c = 0; c < 4; c++) begin
      mixed[4*c +: 4] = inv_mix_col(ark[4*c +: 4]);
    end
  end

  assign state_o = last_i ? ark : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one round per clock, valid/ready on both sides,
// round keys taken straight from the ExpandedKeys bus.
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
#(
  parameter int unsigned NR = 10,
  parameter int unsigned NK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLK_W-1:0]        input_bytes,
  input  logic [BLK_W*(NR+1)-1:0] ExpandedKeys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK_W-1:0]        out
);

  localparam int unsigned RND_W = $clog2(NR + 1);

  if (!(NR == NK + 6 && (NK == 4 || NK == 6 || NK == 8))) begin : g_bad_params
    $error("aes_inv_cipher: NR/NK must be 10/4, 12/6 or 14/8");
  end

  logic [BLK_W-1:0] rk [NR+1];

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = ExpandedKeys[BLK_W*(NR+1-r)-1 -: BLK_W];
  end

  fsm_e             fsm_q;
  logic [RND_W-1:0] rnd_q;
  aes_state_t       state_q;
  logic             out_valid_q;
  logic [BLK_W-1:0] out_q;
  aes_state_t       round_out;
  logic             accept;

  // rnd reaches 0 exactly in LAST, so rk[rnd_q] also serves the final round.
  aes_inv_cipher_round u_round (
    .state_i (state_q),
    .rkey_i  (rk[rnd_q]),
    .last_i  (fsm_q == S_LAST),
    .state_o (round_out)
  );

  assign in_ready  = (fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      state_q     <= input_bytes ^ rk[NR];
      rnd_q       <= RND_W'(NR - 1);
      out_valid_q <= 1'b0;
      fsm_q       <= S_ROUND;
    end else begin
      case (fsm_q)
        S_IDLE: ;
        S_ROUND: begin
          state_q <= round_out;
          rnd_q   <= rnd_q - RND_W'(1);
          if (rnd_q == RND_W'(1)) fsm_q <= S_LAST;
        end
        S_LAST: begin
          state_q     <= round_out;
          out_q       <= round_out;
          out_valid_q <= 1'b1;
          fsm_q       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            fsm_q       <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors plus random blocks against an
// array-based reference decryptor with its own S-box and key expansion.
module tb_aes_inv_cipher;

  logic clk = 1'b0;
  logic rst;
  logic ordy;

  logic iv10, ir10, ov10;
  logic [127:0] ib10, o10;
  logic [128*11-1:0] ek10;
  logic iv12, ir12, ov12;
  logic [127:0] ib12, o12;
  logic [128*13-1:0] ek12;
  logic iv14, ir14, ov14;
  logic [127:0] ib14, o14;
  logic [128*15-1:0] ek14;

  aes_inv_cipher #(.NR(10), .NK(4)) u10 (
    .clk(clk), .reset(rst), .in_valid(iv10), .in_ready(ir10), .input_bytes(ib10),
    .ExpandedKeys(ek10), .out_valid(ov10), .out_ready(ordy), .out(o10));
  aes_inv_cipher #(.NR(12), .NK(6)) u12 (
    .clk(clk), .reset(rst), .in_valid(iv12), .in_ready(ir12), .input_bytes(ib12),
    .ExpandedKeys(ek12), .out_valid(ov12), .out_ready(ordy), .out(o12));
  aes_inv_cipher #(.NR(14), .NK(8)) u14 (
    .clk(clk), .reset(rst), .in_valid(iv14), .in_ready(ir14), .input_bytes(ib14),
    .ExpandedKeys(ek14), .out_valid(ov14), .out_ready(ordy), .out(o14));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]    sbox [256];
  logic [7:0]    isbox [256];
  logic [31:0]   w [60];
  logic [1919:0] bus;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box from multiplicative inverse plus affine map, then inverted.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul8(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  function automatic logic [127:0] rkb(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    bus = '0;
    for (int r = 0; r <= nr; r++) bus[128*(nr+1-r)-1 -: 128] = rkb(r);
  endtask

  // Textbook inverse cipher on a byte array; state byte i is row i%4, column i/4.
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] v;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    v = ct ^ rkb(nr);
    for (int r = nr - 1; r >= 0; r--) begin
      for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
      for (int i = 0; i < 16; i++) t[i] = isbox[s[i%4 + 4*((i/4 - i%4 + 4) % 4)]];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      v = v ^ rkb(r);
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul8(s[4*c+j], coef[(j-row+4)%4]);
            t[4*c+row] = acc;
          end
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] ct);
    int g;
    g = 0;
    ib10 = ct;
    iv10 = 1'b1;
    while (ir10 !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    tick();
    iv10 = 1'b0;
  endtask

  // n = edges after the accept edge until out_valid is seen high.
  task automatic wait_ov(output int n);
    n = 0;
    while (ov10 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic new_key10();
    expand({rnd128(), 128'h0}, 4, 10);
    ek10 = bus[128*11-1:0];
  endtask

  logic [127:0] ct, ct2, ex, ex2;
  logic [127:0] sct [4];
  logic [127:0] sex [4];
  logic         acc;
  int           n, l10, l12, l14, sent, got, cyc, last_cyc;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    rst = 1'b1; ordy = 1'b1;
    iv10 = 1'b0; iv12 = 1'b0; iv14 = 1'b0;
    ib10 = '0; ib12 = '0; ib14 = '0;
    ek10 = '0; ek12 = '0; ek14 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_out_valid", 128'(ov10), 128'(0));
    chk("reset_out", o10, 128'h0);
    chk("reset_in_ready", 128'(ir10), 128'(1));

    // FIPS-197 Appendix B
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
    ek10 = bus[128*11-1:0];
    chk("ref_model_appB", ref_dec(128'h3925841d02dc09fbdc118597196a0b32, 10),
        128'h3243f6a8885a308d313198a2e0370734);
    send(128'h3925841d02dc09fbdc118597196a0b32);
    wait_ov(n);
    chk("appB_latency", 128'(n + 1), 128'(11));
    chk("appB_out", o10, 128'h3243f6a8885a308d313198a2e0370734);
    tick();

    // FIPS-197 Appendix C, all three key sizes at once
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 4, 10);
    ek10 = bus[128*11-1:0];
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 6, 12);
    ek12 = bus[128*13-1:0];
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    ek14 = bus[128*15-1:0];
    ordy = 1'b0;
    ib10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; iv10 = 1'b1;
    ib12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191; iv12 = 1'b1;
    ib14 = 128'h8ea2b7ca516745bfeafc49904b496089; iv14 = 1'b1;
    tick();
    iv10 = 1'b0; iv12 = 1'b0; iv14 = 1'b0;
    l10 = -1; l12 = -1; l14 = -1;
    for (int k = 0; k < 20; k++) begin
      if (ov10 === 1'b1 && l10 < 0) l10 = k;
      if (ov12 === 1'b1 && l12 < 0) l12 = k;
      if (ov14 === 1'b1 && l14 < 0) l14 = k;
      tick();
    end
    chk("appC_nr10_out", o10, 128'h00112233445566778899aabbccddeeff);
    chk("appC_nr12_out", o12, 128'h00112233445566778899aabbccddeeff);
    chk("appC_nr14_out", o14, 128'h00112233445566778899aabbccddeeff);
    chk("appC_nr10_latency", 128'(l10 + 1), 128'(11));
    chk("appC_nr12_latency", 128'(l12 + 1), 128'(13));
    chk("appC_nr14_latency", 128'(l14 + 1), 128'(15));
    ordy = 1'b1;
    tick();

    // Backpressure, then back-to-back accept from DONE
    new_key10();
    ct = rnd128(); ex = ref_dec(ct, 10);
    ordy = 1'b0;
    send(ct);
    wait_ov(n);
    chk("bp_latency", 128'(n + 1), 128'(11));
    for (int k = 0; k < 20; k++) begin
      chk("bp_out_valid_held", 128'(ov10), 128'(1));
      chk("bp_out_held", o10, ex);
      chk("bp_in_ready_low", 128'(ir10), 128'(0));
      tick();
    end
    ct2 = rnd128(); ex2 = ref_dec(ct2, 10);
    ib10 = ct2; iv10 = 1'b1; ordy = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(ir10), 128'(1));
    tick();
    iv10 = 1'b0;
    chk("b2b_valid_drops", 128'(ov10), 128'(0));
    chk("b2b_out_holds", o10, ex);
    wait_ov(n);
    chk("b2b_latency", 128'(n + 1), 128'(11));
    chk("b2b_out", o10, ex2);
    tick();

    // Streaming four blocks with both sides always ready
    new_key10();
    for (int k = 0; k < 4; k++) begin
      sct[k] = rnd128();
      sex[k] = ref_dec(sct[k], 10);
    end
    sent = 0; got = 0; cyc = 0; last_cyc = 0;
    ib10 = sct[0]; iv10 = 1'b1;
    while (got < 4 && cyc < 200) begin
      acc = iv10 & ir10;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 4) ib10 = sct[sent];
        else iv10 = 1'b0;
      end
      if (ov10 === 1'b1) begin
        chk("stream_out", o10, sex[got]);
        if (got > 0) chk("stream_interval", 128'(cyc - last_cyc), 128'(11));
        last_cyc = cyc;
        got++;
      end
    end
    iv10 = 1'b0;
    chk("stream_count", 128'(got), 128'(4));
    tick();

    // Reset mid-block, then a fresh block
    new_key10();
    send(rnd128());
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 128'(ov10), 128'(0));
    chk("midrst_out", o10, 128'h0);
    chk("midrst_in_ready", 128'(ir10), 128'(1));
    ct = rnd128(); ex = ref_dec(ct, 10);
    send(ct);
    wait_ov(n);
    chk("post_rst_latency", 128'(n + 1), 128'(11));
    chk("post_rst_out", o10, ex);
    tick();

    // in_valid pulsed while rounds are in flight
    ct = rnd128(); ex = ref_dec(ct, 10);
    send(ct);
    tick(); tick();
    ib10 = rnd128(); iv10 = 1'b1;
    #1;
    chk("busy_in_ready_low", 128'(ir10), 128'(0));
    tick();
    iv10 = 1'b0;
    wait_ov(n);
    chk("busy_latency", 128'(n + 3 + 1), 128'(11));
    chk("busy_out", o10, ex);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
